int_exec_issue_arbiter: RTL and testbench
=========================================

Name: int_exec_issue_arbiter

Overview:
- Round-robin issue scheduler for the integer vector execution pipeline: one instruction per cycle, chosen from up to NUM_ENTRIES reservation-station entries.
- Drives the operation code and reservation-station id into the pipeline and generates its stall.
- Tracks the single in-flight result stage and hands results to writeback with a valid/ready handshake.
- Supports a flush/drain sequence used on block or warp teardown.

Parameters:
- NUM_ENTRIES, 4, number of reservation-station entries (matches RSV_CAPACITY).
- RID_W, 2, width of the reservation-station id; must equal clog2(NUM_ENTRIES).
- OP_W, 8, width of the function code.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_ENTRIES  per-entry "operands ready, wants int exec".
- req_op  in  NUM_ENTRIES*OP_W  per-entry function code; entry i occupies bits [i*OP_W +: OP_W].
- grant  out  NUM_ENTRIES  one-hot; the entry issued this cycle; all zero when nothing issues.
- issue_valid  out  1  an instruction issues this cycle.
- issue_rid  out  RID_W  id of the granted entry; 0 when not issuing.
- issue_op  out  OP_W  function code of the granted entry; 0 when not issuing.
- exec_stall  out  1  stall to the execution pipeline.
- wb_valid  out  1  the pipeline output holds a valid result.
- wb_rid  out  RID_W  id associated with the result.
- wb_ready  in  1  writeback accepts the result this cycle.
- flush_req  in  1  level; stop issuing and drain.
- flush_done  out  1  level; asserted while draining is complete and flush_req is high.
- busy  out  1  wb_valid OR any req bit set.

Behaviour:
- Reset (asynchronous, rst=1) immediately forces:
  - s1_valid=0, s1_rid=0, ptr=0, state=RUN.
  - Outputs: wb_valid=0, wb_rid=0, flush_done=0, exec_stall=0, grant=0, issue_valid=0.
- Reset mid-operation discards the in-flight result; no wb handshake completes.
- Pipeline model:
  - The execution pipeline has one registered stage and holds its output while stall=1.
  - The arbiter mirrors that stage with s1_valid and s1_rid.
  - wb_valid = s1_valid; wb_rid = s1_rid.
  - exec_stall = s1_valid AND NOT wb_ready (combinational).
- Issue enable: issue_en = (state==RUN) AND NOT exec_stall AND NOT flush_req.
- Arbitration (combinational):
  - Search req starting at index ptr, ascending with wrap to 0.
  - The first set bit wins: grant one-hot, issue_rid = winning index, issue_op = its req_op slice.
  - issue_valid = issue_en AND (|req). When issue_valid=0, grant, issue_rid and issue_op are all 0.
- On each clock edge:
  - If issue_valid: s1_valid<=1, s1_rid<=issue_rid, ptr<=(issue_rid+1) mod NUM_ENTRIES.
  - Else if wb_valid AND wb_ready: s1_valid<=0.
  - Else: hold.
- Latency: the result for an instruction issued in cycle t appears with wb_valid in cycle t+1.
- Throughput: 1 instruction per cycle when wb_ready stays high. Issuing and a writeback in the same cycle is legal: the stage is replaced.
- Backpressure:
  - While exec_stall=1, no grant is made; s1 holds; ptr holds.
  - Once wb_ready rises, issue resumes in that same cycle.
- The RS deasserts req[i] the cycle after grant[i]. The arbiter does not mask re-grant.
- State machine:
  - RUN: go to DRAIN when flush_req=1.
  - DRAIN: no issue. flush_done = (s1_valid==0), combinational. Go to RUN when flush_req=0.
  - A pending result in DRAIN still completes through the wb handshake.
- flush_req and req asserted in the same cycle: flush_req wins, and no issue happens that cycle.
- ptr wraps from NUM_ENTRIES-1 to 0.
- NUM_ENTRIES=1 degenerates to a fixed grant; ptr stays 0.

Test Plan:
- Reset then req=4'b1111, wb_ready=1 held. Required grants on cycles 1..4: rid 0,1,2,3, then 0. wb_rid follows one cycle later with wb_valid=1 continuously.
- ptr=2, req=4'b0011. Required: grant=4'b0001, rid=0 (wrap); next ptr=1.
- Issue rid 1; wb_ready=0 for 3 cycles. Required: exec_stall=1, no grant despite req=4'b1000, wb_rid=1 stable. When wb_ready=1: grant=4'b1000 in that same cycle and wb_rid=3 the next cycle.
- In-flight result, then flush_req=1 with req=4'b0101. Required: no grant, flush_done=0 until wb_ready accepts the result, then flush_done=1. flush_req=0 → issue resumes at the ptr value.
- Assert rst mid-stream with wb_valid=1. Required: wb_valid=0, grant=0 and ptr=0 asynchronously. After release with req=4'b0100: grant=4'b0100.
- req_op slices 0x21,0x42,0x05,0xA0 with req=4'b0110. Required: issue_op=0x42 (rid 1), then 0x05 (rid 2).

Source files
------------

// File: rtl/int_exec_issue_arbiter.sv
// Round-robin issue arbiter for the integer vector execution pipeline.
// It tracks the single result stage, drives the writeback handshake and runs the flush/drain sequence.
module int_exec_issue_arbiter #(
  parameter int NUM_ENTRIES = 4,
  parameter int RID_W       = 2,
  parameter int OP_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_ENTRIES-1:0]      req,
  input  logic [NUM_ENTRIES*OP_W-1:0] req_op,
  output logic [NUM_ENTRIES-1:0]      grant,
  output logic                        issue_valid,
  output logic [RID_W-1:0]            issue_rid,
  output logic [OP_W-1:0]             issue_op,
  output logic                        exec_stall,
  output logic                        wb_valid,
  output logic [RID_W-1:0]            wb_rid,
  input  logic                        wb_ready,
  input  logic                        flush_req,
  output logic                        flush_done,
  output logic                        busy
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic             s1_valid_reg;
  logic [RID_W-1:0] s1_rid_reg;
  logic [RID_W-1:0] ptr_reg;
  logic [RID_W-1:0] ptr_next;
  logic [RID_W-1:0] win_rid;
  logic             issue_en;
  logic [OP_W-1:0]  op_arr [NUM_ENTRIES];

  generate
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_op_slice
      assign op_arr[gi] = req_op[gi*OP_W +: OP_W];
    end
  endgenerate

  assign exec_stall = s1_valid_reg & ~wb_ready;
  assign wb_valid   = s1_valid_reg;
  assign wb_rid     = s1_rid_reg;
  assign busy       = s1_valid_reg | (|req);

  // Reset also masks the combinational grant path so nothing appears to issue while rst is held.
  assign issue_en = ~rst & (state_reg == RUN) & ~exec_stall & ~flush_req;

  always_comb begin
    logic found;
    found   = 1'b0;
    win_rid = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      logic [RID_W-1:0] idx;
      idx = RID_W'((int'(ptr_reg) + k) % NUM_ENTRIES);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_rid = idx;
      end
    end
  end

  assign issue_valid = issue_en & (|req);
  assign grant       = issue_valid ? (NUM_ENTRIES'(1) << win_rid) : '0;
  assign issue_rid   = issue_valid ? win_rid : '0;
  assign issue_op    = issue_valid ? op_arr[win_rid] : '0;
  assign ptr_next    = (win_rid == RID_W'(NUM_ENTRIES - 1)) ? '0 : win_rid + RID_W'(1);

  always_comb begin
    state_next = state_reg;
    flush_done = 1'b0;
    case (state_reg)
      RUN: begin
        if (flush_req) state_next = DRAIN;
      end
      DRAIN: begin
        flush_done = ~s1_valid_reg & flush_req;
        if (!flush_req) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      s1_valid_reg <= 1'b0;
      s1_rid_reg   <= '0;
      ptr_reg      <= '0;
    end else begin
      state_reg <= state_next;
      // A new issue replaces the stage even when writeback accepts in the same cycle.
      if (issue_valid) begin
        s1_valid_reg <= 1'b1;
        s1_rid_reg   <= win_rid;
        ptr_reg      <= ptr_next;
      end else if (s1_valid_reg && wb_ready) begin
        s1_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_int_exec_issue_arbiter.sv
// Self-checking bench for int_exec_issue_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared each cycle against a behavioural model.
module tb_int_exec_issue_arbiter;
  localparam int N    = 4;
  localparam int RW   = 2;
  localparam int OPW  = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*OPW-1:0] req_op;
  logic [N-1:0]   grant;
  logic           issue_valid;
  logic [RW-1:0]  issue_rid;
  logic [OPW-1:0] issue_op;
  logic           exec_stall;
  logic           wb_valid;
  logic [RW-1:0]  wb_rid;
  logic           wb_ready;
  logic           flush_req;
  logic           flush_done;
  logic           busy;

  int vectors    = 0;
  int miscompares = 0;

  int_exec_issue_arbiter #(.NUM_ENTRIES(N), .RID_W(RW), .OP_W(OPW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .grant(grant),
    .issue_valid(issue_valid), .issue_rid(issue_rid), .issue_op(issue_op),
    .exec_stall(exec_stall), .wb_valid(wb_valid), .wb_rid(wb_rid),
    .wb_ready(wb_ready), .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one result slot, a rotating start index and a draining flag.
  bit m_valid;
  int m_rid;
  int m_ptr;
  bit m_drain;

  typedef struct {
    bit iv;
    int rid;
    bit stall;
    bit fdone;
  } exp_t;

  function automatic exp_t model_eval();
    exp_t e;
    e.iv    = 1'b0;
    e.rid   = 0;
    e.stall = m_valid && !wb_ready;
    e.fdone = m_drain && !m_valid && flush_req;
    if (!rst && !m_drain && !e.stall && !flush_req) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (req[i]) begin
          e.iv  = 1'b1;
          e.rid = i;
          break;
        end
      end
    end
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      m_valid <= 1'b0;
      m_rid   <= 0;
      m_ptr   <= 0;
      m_drain <= 1'b0;
    end else begin
      e = model_eval();
      if (e.iv) begin
        m_valid <= 1'b1;
        m_rid   <= e.rid;
        m_ptr   <= (e.rid + 1) % N;
      end else if (m_valid && wb_ready) begin
        m_valid <= 1'b0;
      end
      if (!m_drain && flush_req) m_drain <= 1'b1;
      else if (m_drain && !flush_req) m_drain <= 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [N-1:0]   g_exp;
    logic [OPW-1:0] op_exp;
    e = model_eval();
    g_exp  = e.iv ? N'(1 << e.rid) : '0;
    op_exp = e.iv ? OPW'(req_op >> (OPW * e.rid)) : '0;
    chk("grant",       grant,       g_exp);
    chk("issue_valid", issue_valid, e.iv);
    chk("issue_rid",   issue_rid,   e.iv ? e.rid : 0);
    chk("issue_op",    issue_op,    op_exp);
    chk("exec_stall",  exec_stall,  e.stall);
    chk("wb_valid",    wb_valid,    m_valid);
    chk("wb_rid",      wb_rid,      m_rid);
    chk("flush_done",  flush_done,  e.fdone);
    chk("busy",        busy,        m_valid || (|req));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; req = '0; req_op = '0; wb_ready = 1'b1; flush_req = 1'b0;
    #2 rst = 1'b1; req = 4'b1111;
    #10;
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rid",   wb_rid,   0);
    chk("rst_grant",    grant,    0);
    chk("rst_issue",    issue_valid, 0);
    chk("rst_stall",    exec_stall, 0);
    chk("rst_fdone",    flush_done, 0);

    // Full round robin with wb_ready held high.
    tick(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      #2;
      chk("rr_grant", grant, 32'(1 << (k % 4)));
      chk("rr_rid", issue_rid, k % 4);
      if (k > 0) begin
        chk("rr_wb_valid", wb_valid, 1);
        chk("rr_wb_rid", wb_rid, (k - 1) % 4);
      end
    end

    // Wrap: bring ptr to 2, then req 0011 must pick entry 0.
    tick(); req = 4'b0010; #2 chk("wrap_setup_rid", issue_rid, 1);
    tick(); req = 4'b0011; #2 chk("wrap_grant", grant, 4'b0001); chk("wrap_rid", issue_rid, 0);
    tick(); req = 4'b0011; #2 chk("wrap_ptr1_grant", grant, 4'b0010);

    // Backpressure holding rid 1.
    for (int k = 0; k < 3; k++) begin
      tick(); req = 4'b1000; wb_ready = 1'b0; #2;
      chk("bp_stall", exec_stall, 1);
      chk("bp_grant", grant, 0);
      chk("bp_wb_rid", wb_rid, 1);
    end
    tick(); wb_ready = 1'b1; #2;
    chk("bp_resume_grant", grant, 4'b1000);
    chk("bp_resume_rid", issue_rid, 3);
    chk("bp_resume_stall", exec_stall, 0);
    tick(); req = '0; #2;
    chk("bp_wb_valid", wb_valid, 1);
    chk("bp_wb_rid3", wb_rid, 3);

    // Flush with a result in flight.
    tick(); req = 4'b0001; wb_ready = 1'b0; #2 chk("fl_issue", grant, 4'b0001);
    tick(); flush_req = 1'b1; req = 4'b0101; #2;
    chk("fl_grant0", grant, 0); chk("fl_done0", flush_done, 0); chk("fl_wbv0", wb_valid, 1);
    tick(); #2 chk("fl_grant1", grant, 0); chk("fl_done1", flush_done, 0);
    tick(); wb_ready = 1'b1; #2 chk("fl_grant2", grant, 0); chk("fl_done2", flush_done, 0);
    tick(); #2 chk("fl_done3", flush_done, 1); chk("fl_wbv3", wb_valid, 0); chk("fl_grant3", grant, 0);
    tick(); flush_req = 1'b0; #2 chk("fl_exit_grant", grant, 0);
    tick(); #2 chk("fl_resume_grant", grant, 4'b0100); chk("fl_resume_rid", issue_rid, 2);

    // Asynchronous reset with a result held under stall.
    tick(); req = 4'b1111; wb_ready = 1'b0; #1;
    chk("ar_pre_wbv", wb_valid, 1);
    rst = 1'b1; #1;
    chk("ar_wbv", wb_valid, 0); chk("ar_grant", grant, 0);
    chk("ar_issue", issue_valid, 0); chk("ar_stall", exec_stall, 0); chk("ar_wb_rid", wb_rid, 0);
    tick(); rst = 1'b0; req = 4'b1010; wb_ready = 1'b1; #2 chk("ar_ptr0_grant", grant, 4'b0010);
    tick(); req = 4'b0100; #2 chk("ar_grant_0100", grant, 4'b0100);

    // Function code slices.
    tick(); req_op = {8'hA0, 8'h05, 8'h42, 8'h21}; req = 4'b0110; #2;
    chk("op_first", issue_op, 8'h42); chk("op_first_rid", issue_rid, 1);
    tick(); #2 chk("op_second", issue_op, 8'h05); chk("op_second_rid", issue_rid, 2);

    // Randomized traffic; the per-cycle compare process checks everything.
    for (int c = 0; c < 800; c++) begin
      tick();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 99) == 0) rst = 1'b1;
      req      = N'($urandom);
      req_op   = $urandom;
      wb_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 11) == 0) flush_req = ~flush_req;
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
